pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/scheduling controller for the 5-stage RV32 pipeline. Tracks destination regs of
//  in-flight instrs (shadow EX/MEM slots), issues registered EX forwarding selects, inserts
//  load-use bubbles, flushes on taken branch/jump, freezes pipeline while data memory is busy.
//  Sits beside ID; outputs drive IF/ID, ID/EX, EX/MEM register enables and EX operand muxes.
// PARAMETERS
//  REG_IDX_W  5   register index width
//  CNT_W      32  width of performance counters
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous reset, active-low (rst==0 resets)
//  id_valid         in   1        ID holds a real instr
//  id_rs1_idx       in   5        ID source 1 index
//  id_rs2_idx       in   5        ID source 2 index
//  id_use_rs1       in   1        ID instr reads rs1
//  id_use_rs2       in   1        ID instr reads rs2
//  id_rd_idx        in   5        ID destination index
//  id_reg_wr        in   1        ID instr writes rd
//  id_mem_rd        in   1        ID instr is a load
//  ex_br_take       in   1        EX resolved taken branch/jal/jalr
//  dm_busy          in   1        data memory access not complete this cycle
//  op1_fw_ctrl      out  2        EX rs1 select: 00 EXFromID, 01 EXFwFromMEM, 10 EXFwFromWB
//  op2_fw_ctrl      out  2        EX rs2 select, same encoding
//  pc_stall         out  1        hold PC
//  ifid_stall       out  1        hold IF/ID
//  idex_stall       out  1        hold ID/EX
//  exmem_stall      out  1        hold EX/MEM and MEM/WB
//  ifid_flush       out  1        IF/ID <= NOP
//  idex_bubble      out  1        ID/EX <= NOP
//  stall_cnt        out  CNT_W    cycles spent in LDUSE or MEMWAIT
//  flush_cnt        out  CNT_W    taken-branch flushes
// BEHAVIOUR
//  Reset: all outputs 0, fw ctrl 00, shadow slots invalid, FSM=RUN, counters 0.
//  Shadows: ex_slot{rd,wr,ld}, mem_slot{rd,wr}; advance on every non-frozen cycle:
//   mem_slot<=ex_slot; ex_slot<=ID fields, or invalid if bubble/flush/!id_valid.
//  Hazard match: slot.wr && slot.rd!=0 && slot.rd==src && use_src. x0 never forwarded.
//  Fw ctrl (registered, valid in the cycle the instr is in EX): ex_slot match ->01,
//   else mem_slot match ->10, else 00. MEM has priority over WB. Holds while frozen; 00 on bubble.
//  Load-use: ex_slot.ld && match on either used src -> 1 bubble: pc_stall=ifid_stall=1,
//   idex_bubble=1; next cycle instr re-evaluated, gets 01/10 as appropriate (load then in MEM->10).
//  FSM (outputs combinational from state+inputs, fw ctrl registered):
//   RUN:     dm_busy -> MEMWAIT (freeze now); else ex_br_take -> flush;
//            else load-use -> LDUSE; else stay.
//   LDUSE:   1 cycle; bubble issued in RUN->LDUSE cycle; back to RUN (dm_busy -> MEMWAIT).
//   MEMWAIT: all four stalls=1, no flush/bubble, shadows+fw ctrl hold; !dm_busy -> RUN.
//  Flush (RUN, ex_br_take, !dm_busy): ifid_flush=1, idex_bubble=1, no stalls; overrides
//   load-use in same cycle; flush_cnt++. Two wrong-path instrs squashed.
//  dm_busy && ex_br_take: freeze first; flush taken in first cycle dm_busy=0 (EX held).
//  stall_cnt++ each cycle with any stall output=1; counters wrap at 2^CNT_W.
//  rst=0 mid-operation: immediate return to reset state next edge, pending flush dropped.
// TESTING
//  add x5 then add x6,x5,x1 back-to-back -> op1_fw_ctrl=01 in EX cycle of 2nd instr.
//  add x5; nop; sub x7,x1,x5 -> op2_fw_ctrl=10; both MEM and WB write x5 -> 01 wins.
//  lw x5; add x6,x5,x5 -> 1 cycle pc_stall/ifid_stall/idex_bubble, then fw 10/10, stall_cnt=1.
//  writes to x0 followed by readers of x0 -> fw ctrl stays 00, no stall.
//  ex_br_take=1 with load-use pending -> ifid_flush=idex_bubble=1, no stall, flush_cnt=1.
//  dm_busy 3 cycles with ex_br_take=1 -> 3 frozen cycles, flush in 4th, stall_cnt=3; rst=0 mid -> all 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and scheduling controller for the 5-stage RV32 pipeline.
// Shadows the destination registers of the instructions in EX and MEM,
// issues registered EX forwarding selects, inserts load-use bubbles,
// flushes on a taken branch/jump and freezes everything while data memory
// is busy. Pipeline control outputs are combinational from state + inputs.
module pipe_hazard_ctrl #(
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1_idx,
  input  logic [REG_IDX_W-1:0] id_rs2_idx,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] id_rd_idx,
  input  logic                 id_reg_wr,
  input  logic                 id_mem_rd,
  input  logic                 ex_br_take,
  input  logic                 dm_busy,
  output logic [1:0]           op1_fw_ctrl,
  output logic [1:0]           op2_fw_ctrl,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 idex_stall,
  output logic                 exmem_stall,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LDUSE,
    ST_MEMWAIT
  } state_e;

  // Forwarding select encoding seen by the EX operand muxes.
  localparam logic [1:0] FW_ID  = 2'b00;
  localparam logic [1:0] FW_MEM = 2'b01;
  localparam logic [1:0] FW_WB  = 2'b10;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 wr;
    logic                 ld;
  } ex_slot_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 wr;
  } mem_slot_t;

  state_e     state_q,     state_d;
  ex_slot_t   ex_slot_q,   ex_slot_d;
  mem_slot_t  mem_slot_q,  mem_slot_d;
  logic [1:0] op1_fw_q,    op1_fw_d;
  logic [1:0] op2_fw_q,    op2_fw_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ld_use;
  logic any_stall;

  // A slot supplies a source only if it writes a non-x0 register of the same index.
  function automatic logic hit(input logic wr, input logic [REG_IDX_W-1:0] rd,
                               input logic [REG_IDX_W-1:0] src, input logic use_src);
    return wr && (rd != '0) && (rd == src) && use_src;
  endfunction

  // Forwarding source for one operand: EX slot (next in MEM) beats MEM slot (next in WB).
  function automatic logic [1:0] fw_sel(input ex_slot_t ex_s, input mem_slot_t mem_s,
                                        input logic [REG_IDX_W-1:0] src, input logic use_src);
    if (hit(ex_s.wr, ex_s.rd, src, use_src))        return FW_MEM;
    else if (hit(mem_s.wr, mem_s.rd, src, use_src)) return FW_WB;
    else                                            return FW_ID;
  endfunction

  // Load in EX feeding the instruction in ID cannot be forwarded in time.
  always_comb begin
    ld_use = id_valid && ex_slot_q.ld &&
             (hit(ex_slot_q.wr, ex_slot_q.rd, id_rs1_idx, id_use_rs1) ||
              hit(ex_slot_q.wr, ex_slot_q.rd, id_rs2_idx, id_use_rs2));
  end

  // Pipeline control decision: memory freeze > taken-branch flush > load-use bubble.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = ST_RUN;
    if (!rst) begin
      state_d = ST_RUN;
    end else if (dm_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      state_d     = ST_MEMWAIT;
    end else if (ex_br_take) begin
      // Squashes the two wrong-path instructions in IF and ID.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_RUN;
    end else if (ld_use && (state_q != ST_LDUSE)) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_LDUSE;
    end
  end

  // Shadow slots and forwarding selects advance on every non-frozen cycle.
  always_comb begin
    ex_slot_d  = ex_slot_q;
    mem_slot_d = mem_slot_q;
    op1_fw_d   = op1_fw_q;
    op2_fw_d   = op2_fw_q;
    if (!exmem_stall) begin
      mem_slot_d.rd = ex_slot_q.rd;
      mem_slot_d.wr = ex_slot_q.wr;
      if (id_valid && !idex_bubble) begin
        ex_slot_d.rd = id_rd_idx;
        ex_slot_d.wr = id_reg_wr;
        ex_slot_d.ld = id_mem_rd;
        op1_fw_d     = fw_sel(ex_slot_q, mem_slot_q, id_rs1_idx, id_use_rs1);
        op2_fw_d     = fw_sel(ex_slot_q, mem_slot_q, id_rs2_idx, id_use_rs2);
      end else begin
        ex_slot_d = '0;
        op1_fw_d  = FW_ID;
        op2_fw_d  = FW_ID;
      end
    end
  end

  // Performance counters, free-running and wrapping.
  always_comb begin
    any_stall   = pc_stall | ifid_stall | idex_stall | exmem_stall;
    stall_cnt_d = stall_cnt_q + CNT_W'(any_stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= ST_RUN;
      ex_slot_q   <= '0;
      mem_slot_q  <= '0;
      op1_fw_q    <= FW_ID;
      op2_fw_q    <= FW_ID;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_slot_q   <= ex_slot_d;
      mem_slot_q  <= mem_slot_d;
      op1_fw_q    <= op1_fw_d;
      op2_fw_q    <= op2_fw_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign op1_fw_ctrl = op1_fw_q;
  assign op2_fw_ctrl = op2_fw_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1_idx, id_rs2_idx, id_rd_idx;
  logic        id_use_rs1, id_use_rs2, id_reg_wr, id_mem_rd;
  logic        ex_br_take, dm_busy;
  logic [1:0]  op1_fw_ctrl, op2_fw_ctrl;
  logic        pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_bubble;
  logic [31:0] stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_bubble}
  logic [5:0] ctl;
  logic [3:0] fw;
  assign ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_bubble};
  assign fw  = {op1_fw_ctrl, op2_fw_ctrl};

  pipe_hazard_ctrl #(.REG_IDX_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd_idx(id_rd_idx),
    .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .ex_br_take(ex_br_take), .dm_busy(dm_busy),
    .op1_fw_ctrl(op1_fw_ctrl), .op2_fw_ctrl(op2_fw_ctrl),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Put an instruction (or bubble with v=0) into ID.
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld);
    id_valid = v; id_rs1_idx = rs1; id_rs2_idx = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd_idx = rd; id_reg_wr = wr; id_mem_rd = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_br_take = 1'b0;
    dm_busy    = 1'b0;
  endtask

  // Move to the next cycle: inputs change 2 time units after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b0;
    idle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    dm_busy = 1'b1;
    ex_br_take = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    total++; if (ctl !== 6'b000000) $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b000000); else passed++;
    total++; if (fw !== 4'b0000) $display("FAIL reset_fw got=%b exp=%b", fw, 4'b0000); else passed++;
    total++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); else passed++;
    total++; if (flush_cnt !== 32'd0) $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); else passed++;
    rst = 1'b1;
    idle();
  endtask

  task automatic test_forwarding();
    do_reset();
    // add x5,x1,x2 ; add x6,x5,x1 -> op1 from MEM
    next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    next_cycle(); set_id(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
    #1;
    total++; if (ctl !== 6'b000000) $display("FAIL fw_mem_nostall got=%b exp=%b", ctl, 6'b000000); else passed++;
    next_cycle(); idle(); #1;
    total++; if (fw !== 4'b0100) $display("FAIL fw_mem got=%b exp=%b", fw, 4'b0100); else passed++;
    // add x5 ; nop ; sub x7,x1,x5 -> op2 from WB
    next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    next_cycle(); idle();
    next_cycle(); set_id(1, 5'd1, 5'd5, 1, 1, 5'd7, 1, 0);
    next_cycle(); idle(); #1;
    total++; if (fw !== 4'b0010) $display("FAIL fw_wb got=%b exp=%b", fw, 4'b0010); else passed++;
    // add x5 ; add x5 ; add x8,x5,x5 -> MEM wins over WB on both operands
    next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    next_cycle(); set_id(1, 5'd5, 5'd5, 1, 1, 5'd8, 1, 0);
    next_cycle(); idle(); #1;
    total++; if (fw !== 4'b0101) $display("FAIL fw_priority got=%b exp=%b", fw, 4'b0101); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    next_cycle(); set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  // lw x5,0(x1)
    #1;
    total++; if (ctl !== 6'b000000) $display("FAIL lu_load_ctl got=%b exp=%b", ctl, 6'b000000); else passed++;
    next_cycle(); set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);  // add x6,x5,x5
    #1;
    total++; if (ctl !== 6'b110001) $display("FAIL lu_bubble got=%b exp=%b", ctl, 6'b110001); else passed++;
    next_cycle(); #1;  // add held in ID, re-evaluated
    total++; if (ctl !== 6'b000000) $display("FAIL lu_reeval_ctl got=%b exp=%b", ctl, 6'b000000); else passed++;
    total++; if (fw !== 4'b0000) $display("FAIL lu_bubble_fw got=%b exp=%b", fw, 4'b0000); else passed++;
    next_cycle(); idle(); #1;
    total++; if (fw !== 4'b1010) $display("FAIL lu_fw got=%b exp=%b", fw, 4'b1010); else passed++;
    total++; if (stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); else passed++;
  endtask

  task automatic test_x0();
    logic [4:0] rs1_t [5] = '{5'd1, 5'd0, 5'd1, 5'd0, 5'd0};
    logic [4:0] rs2_t [5] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0] rd_t  [5] = '{5'd0, 5'd3, 5'd0, 5'd4, 5'd0};
    logic       v_t   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ld_t  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      set_id(v_t[i], rs1_t[i], rs2_t[i], v_t[i], v_t[i] && (i != 2), rd_t[i], v_t[i], ld_t[i]);
      #1;
      total++;
      if ({ctl, fw} !== 10'b0) $display("FAIL x0_step%0d got=%b exp=%b", i, {ctl, fw}, 10'b0);
      else passed++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    next_cycle(); set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  // lw x5
    next_cycle(); set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);  // load-use pending
    ex_br_take = 1'b1;
    #1;
    total++; if (ctl !== 6'b000011) $display("FAIL flush_ctl got=%b exp=%b", ctl, 6'b000011); else passed++;
    next_cycle(); idle(); #1;
    total++; if (ctl !== 6'b000000) $display("FAIL flush_after_ctl got=%b exp=%b", ctl, 6'b000000); else passed++;
    total++; if (fw !== 4'b0000) $display("FAIL flush_fw got=%b exp=%b", fw, 4'b0000); else passed++;
    total++; if (flush_cnt !== 32'd1) $display("FAIL flush_cnt got=%0d exp=1", flush_cnt); else passed++;
    total++; if (stall_cnt !== 32'd0) $display("FAIL flush_stall_cnt got=%0d exp=0", stall_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    next_cycle(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);  // add x5,x1,x2
    next_cycle(); set_id(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);  // add x6,x5,x1
    next_cycle(); set_id(1, 5'd6, 5'd0, 1, 0, 5'd7, 1, 0);  // wrong path, EX branch taken
    ex_br_take = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      dm_busy = 1'b1;
      #1;
      total++; if (ctl !== 6'b111100) $display("FAIL mw_freeze%0d got=%b exp=%b", i, ctl, 6'b111100); else passed++;
      total++; if (fw !== 4'b0100) $display("FAIL mw_fw_hold%0d got=%b exp=%b", i, fw, 4'b0100); else passed++;
    end
    next_cycle(); dm_busy = 1'b0; #1;
    total++; if (ctl !== 6'b000011) $display("FAIL mw_flush got=%b exp=%b", ctl, 6'b000011); else passed++;
    total++; if (fw !== 4'b0100) $display("FAIL mw_flush_fw got=%b exp=%b", fw, 4'b0100); else passed++;
    total++; if (stall_cnt !== 32'd3) $display("FAIL mw_stall_cnt got=%0d exp=3", stall_cnt); else passed++;
    next_cycle(); idle(); #1;
    total++; if (flush_cnt !== 32'd1) $display("FAIL mw_flush_cnt got=%0d exp=1", flush_cnt); else passed++;
    total++; if ({ctl, fw} !== 10'b0) $display("FAIL mw_after got=%b exp=%b", {ctl, fw}, 10'b0); else passed++;
    // Reset in the middle of a memory wait with a branch pending
    next_cycle(); dm_busy = 1'b1; #1;
    total++; if (ctl !== 6'b111100) $display("FAIL mr_freeze got=%b exp=%b", ctl, 6'b111100); else passed++;
    next_cycle(); rst = 1'b0; ex_br_take = 1'b1; #1;
    total++; if (ctl !== 6'b000000) $display("FAIL mr_in_reset got=%b exp=%b", ctl, 6'b000000); else passed++;
    next_cycle(); rst = 1'b1; idle(); #1;
    total++; if ({ctl, fw} !== 10'b0) $display("FAIL mr_after got=%b exp=%b", {ctl, fw}, 10'b0); else passed++;
    total++; if (stall_cnt !== 32'd0) $display("FAIL mr_stall_cnt got=%0d exp=0", stall_cnt); else passed++;
    total++; if (flush_cnt !== 32'd0) $display("FAIL mr_flush_cnt got=%0d exp=0", flush_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_x0();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
